// File: rtl/pwm_seq.sv
// pwm_seq -- step sequencer feeding one pwm instance from a profile table.
//
// Each table entry holds {hi, lo, rep}. A step drives (hi, lo) to the pwm for
// max(rep,1) whole periods of length max(hi+lo,1). Steps change only on
// period boundaries, so a running period is never cut short.
//
// Ports
//   clk, srst              clock, synchronous active-high reset
//   wr_en/wr_addr/wr_hi/wr_lo/wr_rep   table write port (any state)
//   last_idx, loop         profile end index and wrap enable, sampled at each advance
//   start, stop            single-cycle control pulses (stop wins over start)
//   pwm_en/pwm_hi/pwm_lo   registered drive for pwm.en/hi/lo
//   step_idx               active step
//   busy, done             not-idle flag, one-cycle completion pulse
//
// Build option
//   PWM_SEQ_SOFTSTOP_EN    stop lets the current period finish (DRAIN) and then
//                          pulses done; without it stop drops to IDLE at once.
module pwm_seq #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  parameter  int REP_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_hi,
  input  logic [W-1:0]     wr_lo,
  input  logic [REP_W-1:0] wr_rep,
  input  logic [AW-1:0]    last_idx,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic             pwm_en,
  output logic [W-1:0]     pwm_hi,
  output logic [W-1:0]     pwm_lo,
  output logic [AW-1:0]    step_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN
`ifdef PWM_SEQ_SOFTSTOP_EN
    , S_DRAIN
`endif
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]     tbl_hi_q  [DEPTH];
  logic [W-1:0]     tbl_hi_d  [DEPTH];
  logic [W-1:0]     tbl_lo_q  [DEPTH];
  logic [W-1:0]     tbl_lo_d  [DEPTH];
  logic [REP_W-1:0] tbl_rep_q [DEPTH];
  logic [REP_W-1:0] tbl_rep_d [DEPTH];

  logic             pwm_en_q, pwm_en_d;
  logic [W-1:0]     pwm_hi_q, pwm_hi_d;
  logic [W-1:0]     pwm_lo_q, pwm_lo_d;
  logic [REP_W-1:0] rep_q, rep_d;      // repeat count latched at step entry
  logic [AW-1:0]    step_idx_q, step_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W:0]       pcnt_q, pcnt_d;
  logic [REP_W-1:0] rcnt_q, rcnt_d;

  // Period length uses the latched step values, so table writes to the
  // active entry cannot disturb the running step.
  logic [W:0]       len, len_eff;
  logic             period_end;
  logic [REP_W-1:0] rep_eff, rcnt_inc;
  logic             at_end;

  always_comb begin
    len        = {1'b0, pwm_hi_q} + {1'b0, pwm_lo_q};
    len_eff    = (len == '0) ? (W+1)'(1) : len;
    period_end = (pcnt_q == len_eff - (W+1)'(1));
    rep_eff    = (rep_q == '0) ? REP_W'(1) : rep_q;
    rcnt_inc   = rcnt_q + REP_W'(1);
    // Past last_idx (it was lowered mid-run) the profile keeps going to the
    // top of the table, which is then treated as the end.
    at_end     = (step_idx_q == last_idx) || (step_idx_q == AW'(DEPTH-1));
  end

  logic          enter;
  logic [AW-1:0] enter_idx;
  logic          go_idle;

  always_comb begin
    state_d    = state_q;
    tbl_hi_d   = tbl_hi_q;
    tbl_lo_d   = tbl_lo_q;
    tbl_rep_d  = tbl_rep_q;
    pwm_en_d   = pwm_en_q;
    pwm_hi_d   = pwm_hi_q;
    pwm_lo_d   = pwm_lo_q;
    rep_d      = rep_q;
    step_idx_d = step_idx_q;
    done_d     = 1'b0;
    pcnt_d     = pcnt_q;
    rcnt_d     = rcnt_q;
    enter      = 1'b0;
    enter_idx  = '0;
    go_idle    = 1'b0;

    if (wr_en) begin
      tbl_hi_d[wr_addr]  = wr_hi;
      tbl_lo_d[wr_addr]  = wr_lo;
      tbl_rep_d[wr_addr] = wr_rep;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          enter   = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
`ifdef PWM_SEQ_SOFTSTOP_EN
          // A stop landing on the period-end cycle has nothing left to drain.
          if (period_end) begin
            go_idle = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
            pcnt_d  = pcnt_q + (W+1)'(1);
          end
`else
          go_idle = 1'b1;
`endif
        end else if (period_end) begin
          pcnt_d = '0;
          if (rcnt_inc == rep_eff) begin
            rcnt_d = '0;
            if (!at_end) begin
              enter     = 1'b1;
              enter_idx = step_idx_q + AW'(1);
            end else if (loop) begin
              enter     = 1'b1;
            end else begin
              go_idle = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            rcnt_d = rcnt_inc;
          end
        end else begin
          pcnt_d = pcnt_q + (W+1)'(1);
        end
      end
`ifdef PWM_SEQ_SOFTSTOP_EN
      S_DRAIN: begin
        if (period_end) begin
          go_idle = 1'b1;
          done_d  = 1'b1;
        end else begin
          pcnt_d = pcnt_q + (W+1)'(1);
        end
      end
`endif
      default: go_idle = 1'b1;
    endcase

    if (enter) begin
      step_idx_d = enter_idx;
      pwm_en_d   = 1'b1;
      pwm_hi_d   = tbl_hi_q[enter_idx];
      pwm_lo_d   = tbl_lo_q[enter_idx];
      rep_d      = tbl_rep_q[enter_idx];
      pcnt_d     = '0;
      rcnt_d     = '0;
    end

    if (go_idle) begin
      state_d    = S_IDLE;
      step_idx_d = '0;
      pwm_en_d   = 1'b0;
      pwm_hi_d   = '0;
      pwm_lo_d   = '0;
      rep_d      = '0;
      pcnt_d     = '0;
      rcnt_d     = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_hi_q[i]  <= '0;
        tbl_lo_q[i]  <= '0;
        tbl_rep_q[i] <= '0;
      end
      pwm_en_q   <= 1'b0;
      pwm_hi_q   <= '0;
      pwm_lo_q   <= '0;
      rep_q      <= '0;
      step_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pcnt_q     <= '0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      tbl_hi_q   <= tbl_hi_d;
      tbl_lo_q   <= tbl_lo_d;
      tbl_rep_q  <= tbl_rep_d;
      pwm_en_q   <= pwm_en_d;
      pwm_hi_q   <= pwm_hi_d;
      pwm_lo_q   <= pwm_lo_d;
      rep_q      <= rep_d;
      step_idx_q <= step_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pcnt_q     <= pcnt_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign pwm_en   = pwm_en_q;
  assign pwm_hi   = pwm_hi_q;
  assign pwm_lo   = pwm_lo_q;
  assign step_idx = step_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_seq.sv
// Directed bench for pwm_seq (DEPTH=8, W=8, REP_W=8). Inputs are driven and
// outputs sampled 1 ns after the rising edge; cyc counts edges, t0 marks the
// cycle in which start was asserted so offsets read as t+N.
module tb_pwm_seq;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          srst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_hi, wr_lo, wr_rep;
  logic [AW-1:0] last_idx;
  logic          loop, start, stop;
  logic          pwm_en;
  logic [7:0]    pwm_hi, pwm_lo;
  logic [AW-1:0] step_idx;
  logic          busy, done;

  pwm_seq dut (
    .clk(clk), .srst(srst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_rep(wr_rep),
    .last_idx(last_idx), .loop(loop), .start(start), .stop(stop),
    .pwm_en(pwm_en), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int dc0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d (cyc %0d, t+%0d)", tag, obs, exp, cyc, cyc - t0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < t0 + k) tick();
  endtask

  task automatic wr(input int a, input int h, input int l, input int r);
    wr_en = 1'b1; wr_addr = AW'(a); wr_hi = 8'(h); wr_lo = 8'(l); wr_rep = 8'(r);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int en, input int hi, input int lo,
                         input int idx, input int bsy, input int dn);
    chk({tag, ".en"},   32'(pwm_en),   32'(en));
    chk({tag, ".hi"},   32'(pwm_hi),   32'(hi));
    chk({tag, ".lo"},   32'(pwm_lo),   32'(lo));
    chk({tag, ".idx"},  32'(step_idx), 32'(idx));
    chk({tag, ".busy"}, 32'(busy),     32'(bsy));
    chk({tag, ".done"}, 32'(done),     32'(dn));
  endtask

  task automatic load_base();
    wr(0, 5, 11, 2);
    wr(1, 8, 12, 1);
    wr(2, 2, 8, 3);
  endtask

  initial begin
    srst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_hi = '0; wr_lo = '0; wr_rep = '0;
    last_idx = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    #1;
    tick(); tick();
    srst = 1'b0;
    tick();
    chk_out("reset", 0, 0, 0, 0, 0, 0);

    // stop alone, then stop+start together: both leave the block idle
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("stop_idle", 0, 0, 0, 0, 0, 0);
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk_out("stop_wins", 0, 0, 0, 0, 0, 0);

    // basic three-step profile, loop=0
    load_base();
    last_idx = 3'd2; loop = 1'b0;
    go();
    chk_out("p.t1", 1, 5, 11, 0, 1, 0);
    run_to(32); chk_out("p.t32", 1, 5, 11, 0, 1, 0);
    run_to(33); chk_out("p.t33", 1, 8, 12, 1, 1, 0);
    run_to(52); chk_out("p.t52", 1, 8, 12, 1, 1, 0);
    run_to(53); chk_out("p.t53", 1, 2, 8, 2, 1, 0);
    run_to(82); chk_out("p.t82", 1, 2, 8, 2, 1, 0);
    run_to(83); chk_out("p.t83", 0, 0, 0, 0, 0, 1);
    run_to(84); chk("p.t84.done", 32'(done), 0);

    // loop=1: wraps to step 0, then clearing loop finishes after the next pass
    loop = 1'b1;
    go();
    run_to(82); chk_out("l.t82", 1, 2, 8, 2, 1, 0);
    run_to(83); chk_out("l.t83", 1, 5, 11, 0, 1, 0);
    loop = 1'b0;
    run_to(164); chk_out("l.t164", 1, 2, 8, 2, 1, 0);
    run_to(165); chk_out("l.t165", 0, 0, 0, 0, 0, 1);

    // zero-length entry lasts one cycle; 255+255 lasts 510 cycles
    wr(0, 0, 0, 0);
    wr(1, 255, 255, 1);
    last_idx = 3'd1;
    go();
    chk_out("z.t1", 1, 0, 0, 0, 1, 0);
    run_to(2);   chk_out("z.t2", 1, 255, 255, 1, 1, 0);
    run_to(511); chk_out("z.t511", 1, 255, 255, 1, 1, 0);
    run_to(512); chk_out("z.t512", 0, 0, 0, 0, 0, 1);

    // stop mid-period in step 1
    load_base();
    last_idx = 3'd2;
    go();
    run_to(40);
    dc0 = done_cnt;
    stop = 1'b1; tick(); stop = 1'b0;
`ifdef PWM_SEQ_SOFTSTOP_EN
    chk_out("ss.t41", 1, 8, 12, 1, 1, 0);
    start = 1'b1; tick(); start = 1'b0;   // ignored while draining
    run_to(52); chk_out("ss.t52", 1, 8, 12, 1, 1, 0);
    run_to(53); chk_out("ss.t53", 0, 0, 0, 0, 0, 1);
    run_to(54); chk("ss.ndone", 32'(done_cnt - dc0), 1);
`else
    chk_out("hs.t41", 0, 0, 0, 0, 0, 0);
    run_to(60); chk("hs.ndone", 32'(done_cnt - dc0), 0);
    chk("hs.busy", 32'(busy), 0);
`endif

    // write to the active entry takes effect only at its next entry
    loop = 1'b1;
    go();
    run_to(35);
    wr(1, 20, 30, 1);
    chk_out("w.t36", 1, 8, 12, 1, 1, 0);
    run_to(52);  chk_out("w.t52", 1, 8, 12, 1, 1, 0);
    run_to(83);  chk_out("w.t83", 1, 5, 11, 0, 1, 0);
    run_to(115); chk_out("w.t115", 1, 20, 30, 1, 1, 0);

    // reset mid-run: outputs drop next cycle, table is cleared
    dc0 = done_cnt;
    srst = 1'b1; tick(); srst = 1'b0;
    chk_out("sr", 0, 0, 0, 0, 0, 0);
    chk("sr.ndone", 32'(done_cnt - dc0), 0);
    last_idx = 3'd0; loop = 1'b0;
    go();
    chk_out("sr.t1", 1, 0, 0, 0, 1, 0);
    run_to(2); chk_out("sr.t2", 0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
